// File: rtl/cpu_pkg.sv
// Shared CPU constants: fetch sequencer states, pacing phases and opcode field layout.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALTED, FINISHED} seq_state_t;

  localparam logic [3:0] OP_BR    = 4'b1111;
  // PC advances in PH_PC; the instruction latches in PH_LATCH, which is also the frozen value.
  localparam logic [1:0] PH_PC    = 2'd0;
  localparam logic [1:0] PH_LATCH = 2'd1;
  localparam logic [1:0] PH_HOLD  = 2'd1;

  localparam int OPC_HI = 8;
  localparam int OPC_LO = 5;
  localparam int IDX_HI = 4;
endpackage

// File: rtl/fetch_sequencer.sv
// Paces the PC with a 4-phase counter, latches fetched instructions, decodes
// relative branches and sequences start/halt across NPROG programs.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int IW    = 9,
  parameter int NPROG = 3
) (
  input  logic          CLK,
  input  logic          Init,
  input  logic          Start,
  input  logic          Halt,
  input  logic [11:0]   PC,
  input  logic [IW-1:0] Inst_in,
  output logic [11:0]   Inst_addr,
  output logic [1:0]    Counter,
  output logic [IW-1:0] Inst_reg,
  output logic          Branch_rel_en,
  output logic [7:0]    Target,
  output logic          Running,
  output logic          Done,
  output logic [1:0]    Prog_cnt
);
  seq_state_t state;
  logic       last_prog;

  assign Inst_addr = PC;
  assign Running   = (state == RUN);
  assign last_prog = (int'(Prog_cnt) + 1 >= NPROG);

  always_ff @(posedge CLK) begin
    if (Init) begin
      state    <= IDLE;
      Counter  <= PH_HOLD;
      Inst_reg <= '0;
      Prog_cnt <= 2'd0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE, HALTED: begin
          // Resume from the held phase so the first phase seen in RUN is 2.
          if (Start) begin
            state   <= RUN;
            Counter <= PH_HOLD + 2'd1;
          end else begin
            Counter <= PH_HOLD;
          end
        end
        RUN: begin
          // Halt beats a same-edge Start; the PC takes its last advance on this edge.
          if (Halt) begin
            Done    <= 1'b1;
            Counter <= PH_HOLD;
            if (int'(Prog_cnt) < NPROG) Prog_cnt <= Prog_cnt + 2'd1;
            state   <= last_prog ? FINISHED : HALTED;
          end else begin
            Counter <= Counter + 2'd1;
            if (Counter == PH_LATCH) Inst_reg <= Inst_in;
          end
        end
        default: Counter <= PH_HOLD;
      endcase
    end
  end

  always_comb begin
    Branch_rel_en = Running && (Inst_reg[OPC_HI:OPC_LO] == OP_BR);
    Target        = {3'b000, Inst_reg[IDX_HI:0]};
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a simple PC model advancing on Counter==0 edges.
module tb_fetch_sequencer;
  localparam int IW = 9;

  logic          CLK = 1'b0;
  logic          Init, Start, Halt;
  logic [11:0]   pc;
  logic [IW-1:0] Inst_in;
  logic [11:0]   Inst_addr;
  logic [1:0]    Counter;
  logic [IW-1:0] Inst_reg;
  logic          Branch_rel_en;
  logic [7:0]    Target;
  logic          Running, Done;
  logic [1:0]    Prog_cnt;

  int total = 0;
  int bad   = 0;

  fetch_sequencer #(.IW(IW), .NPROG(3)) dut (
    .CLK(CLK), .Init(Init), .Start(Start), .Halt(Halt), .PC(pc),
    .Inst_in(Inst_in), .Inst_addr(Inst_addr), .Counter(Counter),
    .Inst_reg(Inst_reg), .Branch_rel_en(Branch_rel_en), .Target(Target),
    .Running(Running), .Done(Done), .Prog_cnt(Prog_cnt)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (Init)              pc <= 12'd0;
    else if (Counter == 0) pc <= pc + 12'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_phase(input logic [1:0] ph);
    int n = 0;
    while (Counter !== ph && n < 16) begin step(); n++; end
    chk("wait_phase", 32'(Counter), 32'(ph));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cnt"}, 32'(Counter), 32'd1);
    chk({tag, "_run"}, 32'(Running), 32'd0);
    chk({tag, "_prog"}, 32'(Prog_cnt), 32'd0);
    chk({tag, "_ireg"}, 32'(Inst_reg), 32'd0);
    chk({tag, "_done"}, 32'(Done), 32'd0);
    chk({tag, "_br"}, 32'(Branch_rel_en), 32'd0);
    chk({tag, "_tgt"}, 32'(Target), 32'd0);
  endtask

  task automatic halt_now();
    Halt = 1'b1; step(); Halt = 1'b0;
  endtask

  task automatic start_now();
    Start = 1'b1; step(); Start = 1'b0;
  endtask

  initial begin
    Init = 1'b1; Start = 1'b0; Halt = 1'b0; Inst_in = 9'h0A3;
    step(); step();
    Init = 1'b0;
    check_reset("rst");
    repeat (5) begin
      step();
      chk("idle_cnt", 32'(Counter), 32'd1);
      chk("idle_run", 32'(Running), 32'd0);
    end
    chk("idle_prog", 32'(Prog_cnt), 32'd0);
    chk("idle_pc", 32'(pc), 32'd0);
    chk("addr_pass", 32'(Inst_addr), 32'(pc));

    // Start: phases 2,3,0,1,2; instruction latched on the 1->2 edge.
    start_now();
    chk("start_run", 32'(Running), 32'd1);
    chk("start_cnt", 32'(Counter), 32'd2);
    step(); chk("seq3", 32'(Counter), 32'd3);
    step(); chk("seq0", 32'(Counter), 32'd0);
    step(); chk("seq1", 32'(Counter), 32'd1);
    chk("pc_adv", 32'(pc), 32'd1);
    step(); chk("seq2", 32'(Counter), 32'd2);
    chk("ireg_0a3", 32'(Inst_reg), 32'h0A3);
    chk("br_0a3", 32'(Branch_rel_en), 32'd0);
    chk("tgt_0a3", 32'(Target), 32'd3);

    Inst_in = 9'h1E5;
    step(); step(); step(); step();
    chk("ireg_1e5", 32'(Inst_reg), 32'h1E5);
    step(); step();
    chk("br_phase", 32'(Counter), 32'd0);
    chk("br_en", 32'(Branch_rel_en), 32'd1);
    chk("br_tgt", 32'(Target), 32'd5);
    Inst_in = 9'h040;

    // Run on to PC 169 and halt there.
    begin
      int n = 0;
      while (!(pc == 12'd169 && Counter == 2'd0) && n < 2000) begin step(); n++; end
      chk("reach_169", 32'(pc), 32'd169);
    end
    halt_now();
    chk("h1_done", 32'(Done), 32'd1);
    chk("h1_prog", 32'(Prog_cnt), 32'd1);
    chk("h1_run", 32'(Running), 32'd0);
    chk("h1_cnt", 32'(Counter), 32'd1);
    chk("h1_pc", 32'(pc), 32'd170);
    chk("h1_br", 32'(Branch_rel_en), 32'd0);
    step();
    chk("h1_done_lo", 32'(Done), 32'd0);
    repeat (9) step();
    chk("h1_pc_hold", 32'(pc), 32'd170);
    chk("h1_cnt_hold", 32'(Counter), 32'd1);

    // Halt outside RUN is ignored.
    halt_now();
    chk("h_ign_prog", 32'(Prog_cnt), 32'd1);
    chk("h_ign_done", 32'(Done), 32'd0);

    start_now();
    chk("resume_cnt", 32'(Counter), 32'd2);
    chk("resume_run", 32'(Running), 32'd1);
    wait_phase(2'd0);
    halt_now();
    chk("h2_prog", 32'(Prog_cnt), 32'd2);
    chk("h2_run", 32'(Running), 32'd0);

    start_now();
    wait_phase(2'd0);
    halt_now();
    chk("h3_prog", 32'(Prog_cnt), 32'd3);
    chk("h3_done", 32'(Done), 32'd1);
    chk("h3_run", 32'(Running), 32'd0);
    repeat (2) begin
      start_now();
      chk("fin_cnt", 32'(Counter), 32'd1);
      chk("fin_run", 32'(Running), 32'd0);
    end
    chk("fin_prog", 32'(Prog_cnt), 32'd3);

    Init = 1'b1; step(); Init = 1'b0;
    check_reset("init_fin");

    // Halt and Start on the same edge: Halt wins.
    start_now();
    wait_phase(2'd0);
    Halt = 1'b1; Start = 1'b1; step(); Halt = 1'b0; Start = 1'b0;
    chk("hs_run", 32'(Running), 32'd0);
    chk("hs_prog", 32'(Prog_cnt), 32'd1);
    chk("hs_cnt", 32'(Counter), 32'd1);
    step();
    chk("hs_stay", 32'(Running), 32'd0);

    // Init mid-program at Counter==2, with Start also high.
    start_now();
    step(); step(); step(); step();
    chk("mid_ireg", 32'(Inst_reg), 32'h040);
    chk("mid_phase", 32'(Counter), 32'd2);
    Init = 1'b1; Start = 1'b1; step(); Init = 1'b0; Start = 1'b0;
    check_reset("init_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
